// File: rtl/multicycle_ctrl.sv
// Multicycle control unit for an RV32I-style datapath: sequences FETCH/DECODE/EXEC/MEM/WB
// and falls into an absorbing TRAP on illegal instructions or a data-memory timeout.
module multicycle_ctrl #(
    parameter int IMEM_LAT   = 1,
    parameter int MAX_WAIT   = 15,
    parameter int EXT_BRANCH = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    input  logic        zero,
    input  logic        sgn,
    input  logic        ltu,
    input  logic        dram_ready,
    output logic [1:0]  npc_op,
    output logic [2:0]  sext_op,
    output logic [1:0]  wd_sel,
    output logic        alub_sel,
    output logic [3:0]  alu_op,
    output logic        imem_req,
    output logic        ir_we,
    output logic        pc_we,
    output logic        rf_we,
    output logic        dram_req,
    output logic        dram_we,
    output logic [1:0]  dram_size,
    output logic        dram_uns,
    output logic        trap,
    output logic [2:0]  state
);
    localparam logic [1:0] PC_4 = 2'b00, PC_IMM = 2'b01, PC_JALR = 2'b10;
    localparam logic [2:0] EXT_I = 3'b000, EXT_S = 3'b001, EXT_B = 3'b010, EXT_U = 3'b011, EXT_J = 3'b100;
    localparam logic [1:0] ALU_C = 2'b00, SEXT_EXT = 2'b01, NPC_PC4 = 2'b10, DRAM_RD = 2'b11;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3, ALU_XOR = 4'd4,
                           ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_SLT = 4'd8, ALU_SLTU = 4'd9;
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011, OP_S = 7'b0100011,
                           OP_B = 7'b1100011, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                           OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
    localparam int CNT_MAX = (IMEM_LAT > MAX_WAIT) ? IMEM_LAT : MAX_WAIT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'b000,
        S_DECODE = 3'b001,
        S_EXEC   = 3'b010,
        S_MEM    = 3'b011,
        S_WB     = 3'b100,
        S_TRAP   = 3'b101
    } state_t;

    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_run;

    logic [6:0] w_op;
    logic [2:0] w_f3;
    logic       w_rd_nz, w_is_r, w_is_i, w_is_load, w_is_s, w_is_b, w_is_lui, w_is_auipc, w_is_jal, w_is_jalr;
    logic       w_legal, w_taken, w_alub;
    logic [2:0] w_sext;
    logic [3:0] w_alu;
    logic       w_unused;

    assign w_op       = inst[6:0];
    assign w_f3       = inst[14:12];
    assign w_rd_nz    = (inst[11:7] != 5'd0);
    assign w_is_r     = (w_op == OP_R);
    assign w_is_i     = (w_op == OP_I);
    assign w_is_load  = (w_op == OP_LOAD);
    assign w_is_s     = (w_op == OP_S);
    assign w_is_b     = (w_op == OP_B);
    assign w_is_lui   = (w_op == OP_LUI);
    assign w_is_auipc = (w_op == OP_AUIPC);
    assign w_is_jal   = (w_op == OP_JAL);
    assign w_is_jalr  = (w_op == OP_JALR);
    assign w_unused   = &{1'b0, inst[31], inst[29:15]};
    assign state      = r_state;

    always_comb begin
        w_legal = 1'b1;
        if (!(w_is_r || w_is_i || w_is_load || w_is_s || w_is_b || w_is_lui || w_is_auipc || w_is_jal || w_is_jalr))
            w_legal = 1'b0;
        if (w_is_b && (w_f3[2:1] == 2'b01))
            w_legal = 1'b0;
        if (w_is_b && (w_f3[2:1] == 2'b11) && (EXT_BRANCH == 0))
            w_legal = 1'b0;
        if (w_is_load && ((w_f3 == 3'b011) || (w_f3[2:1] == 2'b11)))
            w_legal = 1'b0;
        if (w_is_s && w_f3[2])
            w_legal = 1'b0;
    end

    always_comb begin
        case (w_f3)
            3'b000:  w_taken = zero;
            3'b001:  w_taken = !zero;
            3'b100:  w_taken = sgn;
            3'b101:  w_taken = !sgn;
            3'b110:  w_taken = ltu;
            3'b111:  w_taken = !ltu;
            default: w_taken = 1'b0;
        endcase
    end

    // ALU B operand is the immediate for everything except register-register ops and branch compares.
    always_comb begin
        w_alu  = ALU_ADD;
        w_sext = EXT_I;
        w_alub = !(w_is_r || w_is_b);
        if (w_is_r || w_is_i) begin
            case (w_f3)
                3'b000:  w_alu = (w_is_r && inst[30]) ? ALU_SUB : ALU_ADD;
                3'b001:  w_alu = ALU_SLL;
                3'b010:  w_alu = ALU_SLT;
                3'b011:  w_alu = ALU_SLTU;
                3'b100:  w_alu = ALU_XOR;
                3'b101:  w_alu = inst[30] ? ALU_SRA : ALU_SRL;
                3'b110:  w_alu = ALU_OR;
                default: w_alu = ALU_AND;
            endcase
        end
        if (w_is_b)
            w_alu = ALU_SUB;
        if (w_is_s)
            w_sext = EXT_S;
        else if (w_is_b)
            w_sext = EXT_B;
        else if (w_is_lui || w_is_auipc)
            w_sext = EXT_U;
        else if (w_is_jal)
            w_sext = EXT_J;
    end

    always_comb begin
        w_next    = r_state;
        w_cnt_nxt = r_cnt;
        npc_op    = PC_4;
        sext_op   = EXT_I;
        wd_sel    = ALU_C;
        alub_sel  = 1'b0;
        alu_op    = ALU_ADD;
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        rf_we     = 1'b0;
        dram_req  = 1'b0;
        dram_we   = 1'b0;
        dram_size = 2'b00;
        dram_uns  = 1'b0;
        trap      = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (r_run) begin
                    imem_req = 1'b1;
                    if (r_cnt == CNT_W'(IMEM_LAT - 1)) begin
                        ir_we  = 1'b1;
                        w_next = S_DECODE;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            S_DECODE: w_next = w_legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                sext_op  = w_sext;
                alub_sel = w_alub;
                alu_op   = w_alu;
                if (w_is_b) begin
                    pc_we  = 1'b1;
                    npc_op = w_taken ? PC_IMM : PC_4;
                    w_next = S_FETCH;
                end else if (w_is_jal || w_is_jalr) begin
                    pc_we  = 1'b1;
                    npc_op = w_is_jal ? PC_IMM : PC_JALR;
                    rf_we  = w_rd_nz;
                    wd_sel = NPC_PC4;
                    w_next = S_FETCH;
                end else if (w_is_load || w_is_s) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                sext_op   = w_sext;
                alub_sel  = w_alub;
                alu_op    = w_alu;
                dram_req  = 1'b1;
                dram_we   = w_is_s;
                dram_size = w_f3[1:0];
                dram_uns  = w_f3[2];
                if (dram_ready) begin
                    if (w_is_s) begin
                        pc_we  = 1'b1;
                        w_next = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (r_cnt == CNT_W'(MAX_WAIT - 1)) begin
                    w_next = S_TRAP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_WB: begin
                sext_op  = w_sext;
                alub_sel = w_alub;
                alu_op   = w_alu;
                rf_we    = w_rd_nz;
                pc_we    = 1'b1;
                wd_sel   = w_is_load ? DRAM_RD : (w_is_lui ? SEXT_EXT : ALU_C);
                w_next   = S_FETCH;
            end
            S_TRAP:  trap = 1'b1;
            default: w_next = S_FETCH;
        endcase
        // Every state entry starts the shared fetch/memory-wait counter from zero.
        if (w_next != r_state)
            w_cnt_nxt = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
            r_run   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: two parameterisations checked cycle by cycle against
// expected per-instruction traces built from the instruction-level rules.
module tb_multicycle_ctrl;
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011, OP_ST = 7'b0100011,
                           OP_BR = 7'b1100011, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                           OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
    localparam logic [2:0] ST_F = 3'd0, ST_D = 3'd1, ST_E = 3'd2, ST_M = 3'd3, ST_W = 3'd4, ST_T = 3'd5;
    localparam logic [1:0] PC_4 = 2'd0, PC_IMM = 2'd1, PC_JALR = 2'd2;
    localparam logic [1:0] WD_ALU = 2'd0, WD_SEXT = 2'd1, WD_PC4 = 2'd2, WD_DRAM = 2'd3;
    localparam logic [2:0] EX_I = 3'd0, EX_S = 3'd1, EX_B = 3'd2, EX_U = 3'd3, EX_J = 3'd4;
    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3, A_XOR = 4'd4,
                           A_SLL = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7, A_SLT = 4'd8, A_SLTU = 4'd9;

    typedef struct packed {
        logic [2:0] st;
        logic imem, irwe, pcwe, rfwe, dreq, dwe, trap;
    } vec_t;

    typedef struct {
        vec_t       v;
        logic [1:0] npc;
        logic       chk_npc;
        logic [1:0] wd;
        logic       chk_wd;
        logic       chk_mem;
        logic [2:0] msz;
        logic       chk_alu;
        logic [4:0] alu;
        logic       chk_sext;
        logic [2:0] sext;
        logic       rdy, fz, fs, fl;
    } step_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst;
    logic        zero, sgn, ltu, dram_ready;
    logic [1:0]  npc_op [2];
    logic [2:0]  sext_op [2];
    logic [1:0]  wd_sel [2];
    logic        alub_sel [2];
    logic [3:0]  alu_op [2];
    logic        imem_req [2];
    logic        ir_we [2];
    logic        pc_we [2];
    logic        rf_we [2];
    logic        dram_req [2];
    logic        dram_we [2];
    logic [1:0]  dram_size [2];
    logic        dram_uns [2];
    logic        trap [2];
    logic [2:0]  state [2];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          sel     = 0;
    step_t       tr[$];
    logic [31:0] cur_inst;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        multicycle_ctrl #(
            .IMEM_LAT  (g == 0 ? 1 : 3),
            .MAX_WAIT  (g == 0 ? 15 : 4),
            .EXT_BRANCH(g == 0 ? 1 : 0)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .inst      (inst),
            .zero      (zero),
            .sgn       (sgn),
            .ltu       (ltu),
            .dram_ready(dram_ready),
            .npc_op    (npc_op[g]),
            .sext_op   (sext_op[g]),
            .wd_sel    (wd_sel[g]),
            .alub_sel  (alub_sel[g]),
            .alu_op    (alu_op[g]),
            .imem_req  (imem_req[g]),
            .ir_we     (ir_we[g]),
            .pc_we     (pc_we[g]),
            .rf_we     (rf_we[g]),
            .dram_req  (dram_req[g]),
            .dram_we   (dram_we[g]),
            .dram_size (dram_size[g]),
            .dram_uns  (dram_uns[g]),
            .trap      (trap[g]),
            .state     (state[g])
        );
    end

    function automatic int lat_of(int s);  return (s != 0) ? 3 : 1;  endfunction
    function automatic int maxw_of(int s); return (s != 0) ? 4 : 15; endfunction
    function automatic int ext_of(int s);  return (s != 0) ? 0 : 1;  endfunction

    function automatic vec_t obs_vec(int s);
        return {state[s], imem_req[s], ir_we[s], pc_we[s], rf_we[s], dram_req[s], dram_we[s], trap[s]};
    endfunction

    task automatic chk(input string tag, input int cyc, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic bit legal(logic [31:0] in, int ext);
        logic [2:0] f3;
        f3 = in[14:12];
        case (in[6:0])
            OP_R, OP_I, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: return 1'b1;
            OP_LD:   return !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
            OP_ST:   return (f3 < 3'd4);
            OP_BR:   return !(f3 == 3'b010 || f3 == 3'b011) && !(f3 >= 3'd6 && ext == 0);
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit taken(logic [2:0] f3, logic z, logic s, logic l);
        case (f3)
            3'b000:  return z;
            3'b001:  return !z;
            3'b100:  return s;
            3'b101:  return !s;
            3'b110:  return l;
            default: return !l;
        endcase
    endfunction

    function automatic logic [4:0] exp_alu(logic [31:0] in);
        logic [3:0] tab [8];
        logic [3:0] a;
        tab = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
        a = A_ADD;
        if (in[6:0] == OP_R || in[6:0] == OP_I) begin
            a = tab[in[14:12]];
            if (in[14:12] == 3'b000 && in[6:0] == OP_R && in[30]) a = A_SUB;
            if (in[14:12] == 3'b101 && in[30]) a = A_SRA;
        end else if (in[6:0] == OP_BR) begin
            a = A_SUB;
        end
        return {(in[6:0] != OP_R && in[6:0] != OP_BR), a};
    endfunction

    function automatic logic [2:0] exp_sext(logic [6:0] op);
        case (op)
            OP_ST:            return EX_S;
            OP_BR:            return EX_B;
            OP_LUI, OP_AUIPC: return EX_U;
            OP_JAL:           return EX_J;
            default:          return EX_I;
        endcase
    endfunction

    function automatic step_t blank(logic [2:0] st);
        step_t s;
        s.v = '0;
        s.v.st = st;
        s.npc = PC_4;    s.chk_npc = 1'b0;
        s.wd = WD_ALU;   s.chk_wd = 1'b0;
        s.chk_mem = 1'b0; s.msz = 3'd0;
        s.chk_alu = 1'b0; s.alu = 5'd0;
        s.chk_sext = 1'b0; s.sext = 3'd0;
        s.rdy = 1'($urandom_range(1));
        s.fz = 1'($urandom_range(1));
        s.fs = 1'($urandom_range(1));
        s.fl = 1'($urandom_range(1));
        return s;
    endfunction

    function automatic void push_trap();
        step_t s;
        for (int i = 0; i < 3; i++) begin
            s = blank(ST_T);
            s.v.trap = 1'b1;
            tr.push_back(s);
        end
    endfunction

    // k = number of MEM cycles without dram_ready before it arrives; fm >= 0 forces {zero,sgn,ltu} in EXEC.
    function automatic void build(logic [31:0] in, int s_idx, int k, int fm);
        step_t      s;
        logic [6:0] op;
        logic [2:0] f3;
        logic       rdnz;
        int         lat, maxw;
        op = in[6:0]; f3 = in[14:12]; rdnz = (in[11:7] != 5'd0);
        lat = lat_of(s_idx); maxw = maxw_of(s_idx);
        cur_inst = in;
        tr.delete();
        for (int i = 0; i < lat; i++) begin
            s = blank(ST_F);
            s.v.imem = 1'b1;
            s.v.irwe = (i == lat - 1);
            tr.push_back(s);
        end
        tr.push_back(blank(ST_D));
        if (!legal(in, ext_of(s_idx))) begin
            push_trap();
            return;
        end
        s = blank(ST_E);
        s.chk_alu = 1'b1; s.alu = exp_alu(in);
        s.chk_sext = (op != OP_R); s.sext = exp_sext(op);
        if (fm >= 0) {s.fz, s.fs, s.fl} = fm[2:0];
        if (op == OP_BR) begin
            s.v.pcwe = 1'b1; s.chk_npc = 1'b1;
            s.npc = taken(f3, s.fz, s.fs, s.fl) ? PC_IMM : PC_4;
            tr.push_back(s);
            return;
        end
        if (op == OP_JAL || op == OP_JALR) begin
            s.v.pcwe = 1'b1; s.chk_npc = 1'b1;
            s.npc = (op == OP_JAL) ? PC_IMM : PC_JALR;
            s.v.rfwe = rdnz; s.chk_wd = 1'b1; s.wd = WD_PC4;
            tr.push_back(s);
            return;
        end
        tr.push_back(s);
        if (op == OP_LD || op == OP_ST) begin
            for (int j = 0; j <= k && j < maxw; j++) begin
                s = blank(ST_M);
                s.v.dreq = 1'b1; s.v.dwe = (op == OP_ST);
                s.chk_mem = 1'b1; s.msz = f3;
                s.rdy = (j == k);
                if (j == k && op == OP_ST) begin
                    s.v.pcwe = 1'b1; s.chk_npc = 1'b1; s.npc = PC_4;
                end
                tr.push_back(s);
            end
            if (k >= maxw) begin
                push_trap();
                return;
            end
            if (op == OP_ST) return;
        end
        s = blank(ST_W);
        s.v.rfwe = rdnz; s.v.pcwe = 1'b1;
        s.chk_npc = 1'b1; s.npc = PC_4;
        s.chk_wd = 1'b1;
        s.wd = (op == OP_LD) ? WD_DRAM : ((op == OP_LUI) ? WD_SEXT : WD_ALU);
        tr.push_back(s);
    endfunction

    task automatic run_trace(input int max_cyc);
        inst = cur_inst;
        for (int i = 0; i < tr.size() && i < max_cyc; i++) begin
            zero = tr[i].fz; sgn = tr[i].fs; ltu = tr[i].fl; dram_ready = tr[i].rdy;
            #2;
            chk("vec", i, 16'(obs_vec(sel)), 16'(tr[i].v));
            if (tr[i].chk_npc)  chk("npc_op", i, 16'(npc_op[sel]), 16'(tr[i].npc));
            if (tr[i].chk_wd)   chk("wd_sel", i, 16'(wd_sel[sel]), 16'(tr[i].wd));
            if (tr[i].chk_mem)  chk("dram_fmt", i, 16'({dram_uns[sel], dram_size[sel]}), 16'(tr[i].msz));
            if (tr[i].chk_alu)  chk("alu", i, 16'({alub_sel[sel], alu_op[sel]}), 16'(tr[i].alu));
            if (tr[i].chk_sext) chk("sext_op", i, 16'(sext_op[sel]), 16'(tr[i].sext));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        dram_ready = 1'b1;
        #1;
        chk("rst_vec", 0, 16'(obs_vec(sel)), 16'd0);
        chk("rst_npc", 0, 16'(npc_op[sel]), 16'(PC_4));
        chk("rst_alu", 0, 16'(alu_op[sel]), 16'(A_ADD));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("pre_imem", 0, 16'(imem_req[sel]), 16'd0);
        @(posedge clk);
        #1;
        chk("first_imem", 0, 16'({state[sel], imem_req[sel]}), 16'({ST_F, 1'b1}));
    endtask

    function automatic logic [31:0] enc_b(logic [2:0] f3, logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], OP_BR};
    endfunction

    function automatic logic [31:0] enc_s(logic [2:0] f3);
        return {7'd0, 5'd2, 5'd0, f3, 5'd0, OP_ST};
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [6:0]  ops [10];
        ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, 7'h7f};
        r = $urandom();
        r[6:0] = ops[$urandom_range(9)];
        if (r[6:0] == 7'h7f) r[6:0] = 7'($urandom());
        if ($urandom_range(5) == 0) r[11:7] = 5'd0;
        return r;
    endfunction

    initial begin
        logic [31:0] bi;
        rst_n = 1'b0; inst = 32'h0000_0013; zero = 1'b0; sgn = 1'b0; ltu = 1'b0; dram_ready = 1'b0;
        repeat (2) @(posedge clk);
        sel = 0;
        do_reset();
        build(32'h0050_0093, 0, 0, -1);          run_trace(1000);  // addi x1,x0,5
        build(32'h0000_2103, 0, 2, -1);          run_trace(1000);  // lw x2,0(x0)
        bi = enc_b(3'b110, 13'd8);
        build(bi, 0, 0, 3'b001);                 run_trace(1000);  // bltu taken
        build(bi, 0, 0, 3'b000);                 run_trace(1000);  // bltu not taken
        sel = 1;
        do_reset();
        build(bi, 1, 0, 3'b001);                 run_trace(1000);  // bltu illegal without EXT_BRANCH
        sel = 0;
        do_reset();
        build(enc_s(3'b010), 0, 100, -1);        run_trace(1000);  // sw, never ready
        do_reset();
        build(32'h0020_8033, 0, 0, -1);          run_trace(1000);  // add x0,x1,x2
        build(enc_s(3'b000), 0, 100, -1);        run_trace(5);     // sb, stop inside MEM
        chk("sb_mem_req", 0, 16'({state[0], dram_req[0]}), 16'({ST_M, 1'b1}));
        do_reset();
        build(32'h0050_0093, 0, 0, -1);          run_trace(1000);
        sel = 1;
        do_reset();
        build(32'h0000_4103, 1, 1, -1);          run_trace(1000);  // lbu, short wait
        build(enc_s(3'b001), 1, 4, -1);          run_trace(1000);  // sh, timeout at MAX_WAIT=4

        for (int r = 0; r < 30; r++) begin
            sel = int'($urandom_range(1));
            do_reset();
            for (int n = 0; n < 6; n++) begin
                build(rand_inst(), sel, int'($urandom_range(maxw_of(sel) + 1)), -1);
                run_trace(1000);
                if (tr[tr.size() - 1].v.trap) break;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter IMEM_LAT, default 1, is the number of FETCH cycles (fixed latency, >=1) before the instruction word is valid.
REQ-002 Parameter MAX_WAIT, default 15, is the number of dram_req cycles allowed without dram_ready before a trap.
REQ-003 Parameter EXT_BRANCH, default 1; when 1, bltu/bgeu are legal, otherwise they are illegal.
REQ-004 Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- inst  in  32  instruction register contents
- zero, sgn, ltu  in  1 each  ALU result==0, signed less-than, unsigned less-than
- dram_ready  in  1  data memory done
- npc_op  out  2  next-PC select
- sext_op  out  3  immediate format select
- wd_sel  out  2  writeback select
- alub_sel  out  1  ALU B select
- alu_op  out  4  ALU operation
- npc_op, sext_op, wd_sel, alub_sel, alu_op use the shared parameter header encodings.
- imem_req  out  1  fetch strobe
- ir_we  out  1  instruction register load
- pc_we  out  1  PC update
- rf_we  out  1  register write
- dram_req, dram_we  out  1 each  data access request and write
- dram_size  out  2  byte=00, half=01, word=10, taken from funct3[1:0]
- dram_uns  out  1  zero-extend load, funct3[2]
- trap  out  1  sticky fault
- state  out  3  current state

Function
REQ-005 The block SHALL be a Moore/Mealy FSM with states FETCH=000, DECODE=001, EXEC=010, MEM=011, WB=100, TRAP=101.
REQ-006 FETCH SHALL assert imem_req for IMEM_LAT cycles, then assert ir_we on the last cycle and go to DECODE.
REQ-007 DECODE SHALL go to TRAP when any of these is true, otherwise go to EXEC:
- opcode is not R/I/LOAD/S/B/LUI/AUIPC/JAL/JALR
- funct3 is 010/011 on a branch
- funct3 is 11x on a branch when EXT_BRANCH=0
- load funct3 is 011/11x
- store funct3 is not 0xx
REQ-008 EXEC SHALL drive sext_op, alub_sel and alu_op from the decoded instruction; R/I type adds SLT/SLTU.
REQ-009 In EXEC, the following instructions SHALL assert pc_we and return to FETCH:
- B-type: beq/bne use zero, blt/bge use sgn, bltu/bgeu use ltu, selecting PC_IMM or PC_4.
- JAL/JALR: additionally assert rf_we with wd_sel=NPC_PC4 in the same cycle.
REQ-010 EXEC SHALL route R/I/LUI/AUIPC to WB and LOAD/S to MEM.
REQ-011 MEM SHALL hold dram_req=1, with dram_we=1 for stores, until dram_ready.
- Store with ready: pc_we=1, go to FETCH.
- Load with ready: go to WB.
REQ-012 The MEM wait counter SHALL reset on MEM entry and count cycles with dram_ready=0; reaching MAX_WAIT SHALL go to TRAP with no further writes.
REQ-013 WB SHALL assert rf_we=1 and pc_we=1 (npc_op=PC_4) for exactly one cycle, then go to FETCH.
- wd_sel: ALU_C for R/I/AUIPC, SEXT_EXT for LUI, DRAM_RD for loads.
REQ-014 A write to x0 (rd=0) SHALL be suppressed: rf_we=0.
REQ-015 TRAP SHALL be absorbing: trap=1 and all strobes 0 until reset.
REQ-016 Each of pc_we, rf_we, ir_we and dram_req SHALL be high for at most one state's cycles per instruction; pc_we SHALL pulse exactly once per retired instruction.
REQ-017 dram_ready SHALL be ignored outside MEM.

Reset
REQ-018 rst_n=0 SHALL immediately force the following:
- state=FETCH
- all strobes, trap and counters cleared
- npc_op=PC_4, alu_op=ADD
REQ-019 Reset asserted mid-MEM SHALL drop dram_req in the same cycle without waiting for dram_ready.
REQ-020 The first imem_req SHALL occur on the first clock edge after rst_n deasserts.

Verification
REQ-021 addi x1,x0,5 (0x00500093), IMEM_LAT=1 -> states FETCH,DECODE,EXEC,WB; rf_we=1 only in cycle 4; pc_we=1 once.
REQ-022 lw x2,0(x0), dram_ready high after 2 cycles in MEM -> dram_req high 3 cycles, dram_size=10, then WB with wd_sel=DRAM_RD; 7 cycles total.
REQ-023 bltu taken with ltu=1, then the same instruction with EXT_BRANCH=0 -> npc_op=PC_IMM with pc_we in EXEC; with EXT_BRANCH=0, trap=1 after DECODE.
REQ-024 sw, dram_ready never asserted, MAX_WAIT=15 -> TRAP after 15 MEM cycles; dram_we never seen with trap=1; pc_we stays 0.
REQ-025 add x0,x1,x2 -> rf_we stays 0 in WB; pc_we=1.
REQ-026 rst_n low during MEM of sb -> dram_req=0 immediately; after release, state=FETCH with imem_req=1.
